// File: rtl/seven_segment_mux.sv
// Multiplexed N-digit seven-segment display driver.
// Scans one digit per slot of CLK_DIV clocks, with a dead band at the start of
// each slot, PWM brightness gating, per-digit hex decode / raw segments,
// decimal points and blanking. Digit data is double-buffered: the CPU writes a
// shadow copy and the scanner only picks it up at the frame boundary, so a
// frame never shows a mix of old and new data.
module seven_segment_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 1000,
  parameter int DEAD_CYCLES    = 2,
  parameter int BRIGHT_W       = 4,
  parameter int EN_ACTIVE_LOW  = 0,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic                    i_Load,
  input  logic [7*NUM_DIGITS-1:0] i_SegData,
  input  logic [NUM_DIGITS-1:0]   i_HexLutEn,
  input  logic [NUM_DIGITS-1:0]   i_Dp,
  input  logic [NUM_DIGITS-1:0]   i_Blank,
  input  logic [BRIGHT_W-1:0]     i_Brightness,
  output logic [NUM_DIGITS-1:0]   o_7Seg_En,
  output logic [6:0]              o_7Seg_Led,
  output logic                    o_7Seg_Dp,
  output logic                    o_FrameDone
);

  // Counter widths; a single digit or a divide-by-one still needs one bit.
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] DEAD_END = PRE_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Physical "off" levels of the pins, taking the polarity options into account.
  localparam logic [NUM_DIGITS-1:0] EN_OFF =
    (EN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  // Hex nibble to segment pattern, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

  // Scan state
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;

  // Shadow (CPU side) and active (scanner side) digit data
  logic [7*NUM_DIGITS-1:0] sh_seg_q, sh_seg_d;
  logic [NUM_DIGITS-1:0]   sh_hex_q, sh_hex_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [7*NUM_DIGITS-1:0] act_seg_q, act_seg_d;
  logic [NUM_DIGITS-1:0]   act_hex_q, act_hex_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;

  // Output registers (hold physical pin levels)
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [6:0]            led_q, led_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  // Combinational helpers
  logic                  slot_last;
  logic                  wrap;
  logic [6:0]            digit_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_sel;
  logic [6:0]            slot_seg;
  logic                  slot_dp;
  logic                  slot_blank;
  logic                  pwm_on;
  logic                  lit;

  assign slot_last = (presc_q == PRE_LAST);
  assign wrap      = slot_last && (idx_q == IDX_LAST);

  // Per-digit segment pattern (decoded or raw) and one-hot digit select.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [6:0] raw;
    assign raw            = act_seg_q[7*gi +: 7];
    assign digit_seg[gi]  = act_hex_q[gi] ? hex_to_seg(raw[3:0]) : raw;
    assign digit_sel[gi]  = (idx_q == IDX_W'(gi));
  end

  // Pick the current digit's pattern, decimal point and blank flag.
  always_comb begin
    slot_seg   = 7'h00;
    slot_dp    = 1'b0;
    slot_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_sel[k]) begin
        slot_seg   = digit_seg[k];
        slot_dp    = act_dp_q[k];
        slot_blank = act_blank_q[k];
      end
    end
  end

  // Digit is lit outside the dead band, when not blanked, and in the PWM on-phase.
  // Brightness is taken live so a change shows on the very next clock.
  always_comb begin
    pwm_on = (&i_Brightness) || (pwm_q < i_Brightness);
    lit    = (presc_q >= DEAD_END) && !slot_blank && pwm_on;
  end

  // Next-state for prescaler, digit index and PWM counter.
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    pwm_d   = pwm_q + BRIGHT_W'(1);
    if (slot_last) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Next-state for the double buffer: load into shadow, promote at frame wrap.
  // On a load coinciding with the wrap, active takes the old shadow contents.
  always_comb begin
    sh_seg_d    = sh_seg_q;
    sh_hex_d    = sh_hex_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    act_seg_d   = act_seg_q;
    act_hex_d   = act_hex_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    if (i_Load) begin
      sh_seg_d   = i_SegData;
      sh_hex_d   = i_HexLutEn;
      sh_dp_d    = i_Dp;
      sh_blank_d = i_Blank;
    end
    if (wrap) begin
      act_seg_d   = sh_seg_q;
      act_hex_d   = sh_hex_q;
      act_dp_d    = sh_dp_q;
      act_blank_d = sh_blank_q;
    end
  end

  // Next output values, converted to pin polarity.
  always_comb begin
    en_d         = EN_OFF;
    led_d        = SEG_OFF;
    dp_d         = DP_OFF;
    frame_done_d = wrap;
    if (lit) begin
      en_d = digit_sel ^ EN_OFF;
    end
    led_d = slot_seg ^ SEG_OFF;
    dp_d  = slot_dp ^ DP_OFF;
  end

  // Scan counters.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
    end
  end

  // Shadow and active digit data.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sh_seg_q    <= '0;
      sh_hex_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      act_seg_q   <= '0;
      act_hex_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
    end else begin
      sh_seg_q    <= sh_seg_d;
      sh_hex_q    <= sh_hex_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      act_seg_q   <= act_seg_d;
      act_hex_q   <= act_hex_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
    end
  end

  // Registered pin drivers; reset forces every pin to its inactive level at once.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      en_q         <= EN_OFF;
      led_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      en_q         <= en_d;
      led_q        <= led_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_7Seg_En   = en_q;
  assign o_7Seg_Led  = led_q;
  assign o_7Seg_Dp   = dp_q;
  assign o_FrameDone = frame_done_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Testbench for seven_segment_mux: two instances (fast scan / active-high pins,
// slow scan / active-low pins) driven by shared stimulus and checked every
// clock against a frame-level reference model.
module tb_seven_segment_mux;

  localparam int N    = 4;
  localparam int CD_A = 8;
  localparam int CD_B = 64;
  localparam int DEAD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        load;
  logic [27:0] seg;
  logic [3:0]  hex, dp, blank, bright;

  logic [3:0] en_a, en_b;
  logic [6:0] led_a, led_b;
  logic       dp_a, dp_b, fd_a, fd_b;

  seven_segment_mux #(
    .NUM_DIGITS(N), .CLK_DIV(CD_A), .DEAD_CYCLES(DEAD), .BRIGHT_W(4),
    .EN_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Load(load), .i_SegData(seg),
    .i_HexLutEn(hex), .i_Dp(dp), .i_Blank(blank), .i_Brightness(bright),
    .o_7Seg_En(en_a), .o_7Seg_Led(led_a), .o_7Seg_Dp(dp_a), .o_FrameDone(fd_a)
  );

  seven_segment_mux #(
    .NUM_DIGITS(N), .CLK_DIV(CD_B), .DEAD_CYCLES(DEAD), .BRIGHT_W(4),
    .EN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Load(load), .i_SegData(seg),
    .i_HexLutEn(hex), .i_Dp(dp), .i_Blank(blank), .i_Brightness(bright),
    .o_7Seg_En(en_b), .o_7Seg_Led(led_b), .o_7Seg_Dp(dp_b), .o_FrameDone(fd_b)
  );

  typedef struct packed {
    logic [27:0] seg;
    logic [3:0]  hex;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } frame_t;

  frame_t     m_shadow, m_act_a, m_act_b;
  int         t_a, t_b;          // clocks since reset release
  int         errors = 0;
  int         checks = 0;
  logic [6:0] lut [16];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // What the pins should show after a clock edge, from the scan position t.
  function automatic void model_out(input int cd, input int t, input frame_t act,
                                    input logic [3:0] b, input bit inv_en, input bit inv_seg,
                                    output logic [3:0] e, output logic [6:0] l, output logic d);
    int presc, idx, pwm;
    logic [6:0] raw;
    presc = t % cd;
    idx   = (t / cd) % N;
    pwm   = t % 16;
    e = 4'b0000;
    if (presc >= DEAD && !act.blank[idx] && (b == 4'hF || pwm < int'(b))) e[idx] = 1'b1;
    raw = act.seg[idx*7 +: 7];
    l = act.hex[idx] ? lut[raw[3:0]] : raw;
    d = act.dp[idx];
    if (inv_en) e = ~e;
    if (inv_seg) begin
      l = ~l;
      d = ~d;
    end
  endfunction

  task automatic model_reset();
    t_a = 0; t_b = 0;
    m_shadow = '0; m_act_a = '0; m_act_b = '0;
  endtask

  // One clock: predict, step, compare both instances, advance the model.
  task automatic tick();
    logic [3:0] ea, eb;
    logic [6:0] la, lb;
    logic       da, db, wa, wb;
    model_out(CD_A, t_a, m_act_a, bright, 1'b0, 1'b0, ea, la, da);
    model_out(CD_B, t_b, m_act_b, bright, 1'b1, 1'b1, eb, lb, db);
    wa = (t_a % (CD_A*N)) == CD_A*N - 1;
    wb = (t_b % (CD_B*N)) == CD_B*N - 1;
    @(posedge clk);
    #1;
    check_val("a_en", 32'(en_a), 32'(ea));
    check_val("a_led", 32'(led_a), 32'(la));
    check_val("a_dp", 32'(dp_a), 32'(da));
    check_val("a_fd", 32'(fd_a), 32'(wa));
    check_val("b_en", 32'(en_b), 32'(eb));
    check_val("b_led", 32'(led_b), 32'(lb));
    check_val("b_dp", 32'(dp_b), 32'(db));
    check_val("b_fd", 32'(fd_b), 32'(wb));
    if (wa) m_act_a = m_shadow;
    if (wb) m_act_b = m_shadow;
    if (load) m_shadow = {seg, hex, dp, blank};
    t_a++; t_b++;
  endtask

  task automatic load_once(input logic [27:0] s, input logic [3:0] h, input logic [3:0] p,
                           input logic [3:0] bl);
    seg = s; hex = h; dp = p; blank = bl; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int n;
    lut[0]  = 7'b0111111; lut[1]  = 7'b0000110; lut[2]  = 7'b1011011; lut[3]  = 7'b1001111;
    lut[4]  = 7'b1100110; lut[5]  = 7'b1101101; lut[6]  = 7'b1111101; lut[7]  = 7'b0000111;
    lut[8]  = 7'b1111111; lut[9]  = 7'b1101111; lut[10] = 7'b1110111; lut[11] = 7'b1111100;
    lut[12] = 7'b0111001; lut[13] = 7'b1011110; lut[14] = 7'b1111001; lut[15] = 7'b1110001;

    // Reset values
    rst_n = 1'b0; load = 1'b0; seg = '0; hex = '0; dp = '0; blank = '0; bright = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_a_en", 32'(en_a), 32'h0);
    check_val("rst_a_led", 32'(led_a), 32'h00);
    check_val("rst_a_dp", 32'(dp_a), 32'h0);
    check_val("rst_a_fd", 32'(fd_a), 32'h0);
    check_val("rst_b_en", 32'(en_b), 32'hF);
    check_val("rst_b_led", 32'(led_b), 32'h7F);
    check_val("rst_b_dp", 32'(dp_b), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Hex 1,2,3,4 at full brightness; FrameDone period is 32 clocks on dut_a
    load_once({7'h04, 7'h03, 7'h02, 7'h01}, 4'hF, 4'h0, 4'h0);
    repeat (40) tick();
    n = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (fd_a) n++;
    end
    check_val("fd_period", 32'(n), 32'd2);

    // Raw mode, 0x55 on digit 2 with its decimal point
    load_once({7'h11, 7'h55, 7'h22, 7'h33}, 4'h0, 4'b0100, 4'h0);
    repeat (80) tick();

    // Blank digit 1: its enable must never appear
    load_once({7'h04, 7'h03, 7'h02, 7'h01}, 4'hF, 4'h0, 4'b0010);
    repeat (40) tick();
    n = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (en_a == 4'b0010) n++;
    end
    check_val("blank_dig1", 32'(n), 32'd0);

    // 25% duty, then dark
    load_once({7'h0C, 7'h0A, 7'h0F, 7'h0E}, 4'hF, 4'b1001, 4'h0);
    bright = 4'd4;
    repeat (300) tick();
    bright = 4'd0;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (en_a != 4'h0 || en_b != 4'hF) n++;
    end
    check_val("dark_en", 32'(n), 32'd0);
    bright = 4'hF;

    // Load landing on the same clock as dut_a's frame wrap
    while ((t_a % (CD_A*N)) != CD_A*N - 1) tick();
    load_once({7'h09, 7'h08, 7'h07, 7'h06}, 4'hF, 4'b0001, 4'h0);
    repeat (80) tick();

    // Repeated loads within a frame, random brightness and data
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(7) == 0) begin
        seg = 28'($urandom); hex = 4'($urandom); dp = 4'($urandom);
        blank = 4'($urandom_range(3) == 0 ? $urandom : 0);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(49) == 0) bright = 4'($urandom);
      tick();
    end
    load = 1'b0;

    // Asynchronous reset mid-slot: pins drop to inactive before any edge
    load_once(28'h1234567, 4'hA, 4'hF, 4'h0);
    bright = 4'hF;
    repeat (13) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_a_en", 32'(en_a), 32'h0);
    check_val("arst_a_led", 32'(led_a), 32'h00);
    check_val("arst_a_dp", 32'(dp_a), 32'h0);
    check_val("arst_b_en", 32'(en_b), 32'hF);
    check_val("arst_b_led", 32'(led_b), 32'h7F);
    check_val("arst_b_dp", 32'(dp_b), 32'h1);
    check_val("arst_b_fd", 32'(fd_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (10) tick();
    load_once({7'h0D, 7'h0B, 7'h05, 7'h00}, 4'hF, 4'h2, 4'h0);
    repeat (300) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
